// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter.
package vram_arb_pkg;
   localparam int NREQ = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ptr names the requester favoured on contention.
module rr_arbiter2
   import vram_arb_pkg::*;
(
   input  logic [NREQ-1:0] valid,
   input  logic            ptr,
   output logic [NREQ-1:0] grant
);
   always_comb begin
      grant = valid;
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester single-port VRAM arbiter with a whole-memory fill engine.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   input  logic                   clr_start,
   input  logic [DATA_W-1:0]      clr_value,
   output logic                   clr_busy,
   output logic                   mem_ce,
   output logic                   mem_oce,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_din,
   input  logic [DATA_W-1:0]      mem_dout
);
   localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic              rr_ptr;
   logic [ADDR_W:0]   clr_cnt;
   logic [DATA_W-1:0] clr_val;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   rd_p1;
   logic              gnt_id;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arbiter2 u_rr (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      unique case (state)
         ST_IDLE: begin
            // A fill request pre-empts any grant in the same cycle.
            if (clr_start) state_nxt = ST_CLEAR;
            else           req_ready = grant;
         end
         ST_CLEAR: begin
            if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (reset) req_ready = '0;
   end

   assign accept    = |(req_valid & req_ready);
   assign gnt_id    = req_ready[1];
   assign sel_we    = req_we[gnt_id];
   assign sel_addr  = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
   assign sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rr_ptr    <= 1'b0;
         clr_cnt   <= '0;
         clr_val   <= '0;
         mem_ce    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         rd_p1     <= '0;
         rsp_valid <= '0;
      end else begin
         state     <= state_nxt;
         mem_ce    <= 1'b0;
         mem_we    <= 1'b0;
         rd_p1     <= '0;
         // Memory data lands one cycle after the command, so the tag follows by one.
         rsp_valid <= rd_p1;
         unique case (state)
            ST_IDLE: begin
               if (clr_start) begin
                  clr_val <= clr_value;
                  clr_cnt <= '0;
               end else if (accept) begin
                  rr_ptr   <= ~gnt_id;
                  mem_ce   <= 1'b1;
                  mem_we   <= sel_we;
                  mem_addr <= sel_addr;
                  mem_din  <= sel_wdata;
                  rd_p1    <= sel_we ? '0 : req_ready;
               end
            end
            ST_CLEAR: begin
               mem_ce   <= 1'b1;
               mem_we   <= 1'b1;
               mem_addr <= clr_cnt[ADDR_W-1:0];
               mem_din  <= clr_val;
               clr_cnt  <= clr_cnt + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   assign rsp_rdata = (|rsp_valid) ? mem_dout : '0;
   assign clr_busy  = (state == ST_CLEAR);
   assign mem_oce   = 1'b1;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomized + directed bench: reference model predicts grants/bus/responses, monitor scores responses.
module tb_vram_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, clr_value, mem_din, mem_dout;
   logic            clr_start, clr_busy, mem_ce, mem_oce, mem_we;
   logic [AW-1:0]   mem_addr;

   vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clr_start(clr_start),
      .clr_value(clr_value), .clr_busy(clr_busy), .mem_ce(mem_ce), .mem_oce(mem_oce),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with registered read.
   logic [DW-1:0] vmem [DEPTH];
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_we) vmem[mem_addr] <= mem_din;
         else        mem_dout <= vmem[mem_addr];
      end
   end

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   typedef struct { int id; logic [DW-1:0] data; longint due; } rsp_t;
   rsp_t          sbq[$];
   logic [DW-1:0] ref_mem [DEPTH];
   bit            m_busy, m_ptr, exp_ce, exp_we;
   int            m_addr, exp_addr;
   logic [DW-1:0] m_val;

   always @(negedge clk) begin
      logic [1:0] er;
      int id, a;
      if (reset) begin
         m_busy = 0; m_ptr = 0; exp_ce = 0; exp_we = 0;
         sbq.delete();
      end else begin
         chk("mem_ce", mem_ce, exp_ce);
         if (exp_ce) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
         end
         chk("mem_oce", mem_oce, 1);
         chk("clr_busy", clr_busy, m_busy);
         er = 2'b00;
         if (!m_busy && !clr_start) begin
            if (req_valid == 2'b11) er = m_ptr ? 2'b10 : 2'b01;
            else                    er = req_valid;
         end
         chk("req_ready", req_ready, er);
         exp_ce = 0;
         if (er != 0) begin
            id = er[1] ? 1 : 0;
            a  = int'(req_addr[id*AW +: AW]);
            exp_ce = 1; exp_we = req_we[id]; exp_addr = a;
            if (req_we[id]) ref_mem[a] = req_wdata[id*DW +: DW];
            else            sbq.push_back('{id, ref_mem[a], cyc + 2});
            m_ptr = (id == 0);
         end
         if (m_busy) begin
            ref_mem[m_addr] = m_val;
            exp_ce = 1; exp_we = 1; exp_addr = m_addr;
            m_addr++;
            if (m_addr == DEPTH) m_busy = 0;
         end else if (clr_start) begin
            m_busy = 1; m_addr = 0; m_val = clr_value;
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin
      logic [1:0] ev;
      if (!reset) begin
         ev = 2'b00;
         if (sbq.size() > 0 && sbq[0].due == cyc) ev = (sbq[0].id == 1) ? 2'b10 : 2'b01;
         chk("rsp_valid", rsp_valid, ev);
         if (ev != 0) begin
            chk("rsp_rdata", rsp_rdata, sbq[0].data);
            void'(sbq.pop_front());
         end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            chk("rsp_missing", 0, 1);
            void'(sbq.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input int i, input bit v, input bit we, input int a, input int d);
      req_valid[i] = v;
      req_we[i]    = we;
      req_addr[i*AW +: AW]  = a[AW-1:0];
      req_wdata[i*DW +: DW] = d[DW-1:0];
   endtask

   task automatic issue(input int i, input bit we, input int a, input int d);
      int n;
      n = 0;
      drive(i, 1, we, a, d);
      @(negedge clk);
      while (!req_ready[i] && n < 50) begin n++; @(negedge clk); end
      chk("issue_timeout", (n >= 50), 0);
      step();
      req_valid[i] = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sbq.size() > 0 || clr_busy) && n < 6000) begin n++; step(); end
      chk("drain_timeout", (n >= 6000), 0);
   endtask

   initial begin
      int n;
      reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
      clr_start = 1; clr_value = 8'hFF;
      step(); req_valid = 2'b11; step();
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_mem_ce", mem_ce, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      step();
      reset = 0; clr_start = 0; req_valid = 0;
      step();

      // single write then read
      issue(0, 1, 12'h123, 8'hA5);
      issue(0, 0, 12'h123, 0);
      issue(1, 0, 12'h123, 0);
      repeat (3) step();

      // contention: both reading for 4 cycles
      drive(0, 1, 0, 12'h123, 0);
      drive(1, 1, 0, 12'h123, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("cont_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
         step();
      end
      req_valid = 0;
      repeat (3) step();

      // full clear
      clr_value = 8'h3C; clr_start = 1;
      step();
      clr_start = 0;
      n = 0;
      @(negedge clk);
      while (clr_busy && n < 5000) begin n++; @(negedge clk); end
      chk("clr_busy_len", n, DEPTH);
      step();
      issue(0, 0, 12'h000, 0);
      issue(0, 0, 12'h7FF, 0);
      issue(0, 0, 12'hFFF, 0);

      // streaming on req1
      for (int k = 0; k < 16; k++) issue(1, 1, 12'h200 + k, $urandom_range(255));
      for (int k = 0; k < 16; k++) begin
         drive(1, 1, 0, 12'h200 + k, 0);
         step();
      end
      req_valid = 0;
      repeat (3) step();

      // random traffic
      for (int k = 0; k < 300; k++) begin
         drive(0, $urandom_range(1), $urandom_range(1), $urandom_range(DEPTH - 1), $urandom_range(255));
         drive(1, $urandom_range(1), $urandom_range(1), $urandom_range(DEPTH - 1), $urandom_range(255));
         step();
      end
      req_valid = 0;
      repeat (3) step();

      // clear collision, with a read accepted the cycle before the clear starts
      drive(1, 1, 0, 12'h205, 0);
      step();
      req_valid = 0;
      drive(0, 1, 0, 12'h010, 0);
      clr_value = 8'h5A; clr_start = 1;
      @(negedge clk);
      chk("coll_no_grant", req_ready, 0);
      step();
      clr_start = 0;
      n = 0;
      @(negedge clk);
      while (clr_busy && n < 5000) begin n++; @(negedge clk); end
      chk("coll_grant_after", req_ready, 2'b01);
      step();
      req_valid = 0;
      wait_idle();

      // reset in the middle of a fill
      clr_value = 8'hC3; clr_start = 1;
      step();
      clr_start = 0;
      n = 0;
      while (m_addr != 12'h400 && n < 5000) begin n++; @(negedge clk); end
      chk("fill_reach_timeout", (n >= 5000), 0);
      step();
      reset = 1;
      step(); step();
      reset = 0;
      drive(0, 1, 0, 12'h000, 0);
      drive(1, 1, 0, 12'h001, 0);
      @(negedge clk);
      chk("post_rst_grant", req_ready, 2'b01);
      chk("post_rst_busy", clr_busy, 0);
      step(); step();
      req_valid = 0;
      repeat (10) step();

      wait_idle();
      chk("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
